// File: rtl/perf_pkg.sv
// Shared definitions for the performance monitor: counter indices, cache
// state encodings and the monitor FSM state type.
package perf_pkg;

  localparam int NUM_CNT       = 8;

  localparam int CNT_CYCLES    = 0;
  localparam int CNT_STALLS    = 1;
  localparam int CNT_FLUSHES   = 2;
  localparam int CNT_RD_HITS   = 3;
  localparam int CNT_WR_HITS   = 4;
  localparam int CNT_RD_MISSES = 5;
  localparam int CNT_WR_MISSES = 6;
  localparam int CNT_WB_MISSES = 7;

  localparam logic [1:0] CACHE_IDLE  = 2'd0;
  localparam logic [1:0] CACHE_WB    = 2'd1;
  localparam logic [1:0] CACHE_ALLOC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with clear, freeze, wrap-or-saturate and a sticky overflow flag.
// Latency: one cycle from inc_i to count_o; no backpressure.
module perf_counter #(
  parameter int pWidth    = 32,
  parameter int pSaturate = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic              freeze_i,
  output logic [pWidth-1:0] count_o,
  output logic              overflow_o
);

  logic [pWidth-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i && !freeze_i) begin
      if (&cnt_q) begin
        // Overflow is flagged whether the counter wraps or sticks at all-ones.
        ovf_d = 1'b1;
        cnt_d = (pSaturate != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// Pipeline/data-cache performance monitor: eight event counters gated by an IDLE/RUN/DONE FSM.
// Latency: counters update one cycle after the event; count_o is one further registered stage.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int pCounterWidth = 32,
  parameter int pCycleLimit   = 300,
  parameter int pSaturate     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     hazard_stall_i,
  input  logic                     cache_stall_i,
  input  logic [1:0]               cache_state_i,
  input  logic                     cache_read_i,
  input  logic                     cache_write_i,
  input  logic                     pc_mux_ctrl_i,
  input  logic                     flush_i,
  input  logic [2:0]               sel_i,
  output logic [pCounterWidth-1:0] count_o,
  output logic [7:0]               overflow_o,
  output logic                     limit_reached_o
);

  localparam logic [63:0] LIMIT_M1 = 64'(pCycleLimit - 1);

  mon_state_e                 state_q, state_d;
  logic [1:0]                 prev_cache_state_q;
  logic                       miss_pending_q;
  logic                       active;
  logic                       frozen;
  logic                       at_limit;
  logic                       miss_start;
  logic                       hit_ok;
  logic [63:0]                cyc_ext;
  logic [NUM_CNT-1:0]         ev;
  logic [NUM_CNT-1:0]         ovf;
  logic [pCounterWidth-1:0]   cnt [NUM_CNT];
  logic [pCounterWidth-1:0]   count_q;

  assign active   = (state_q == ST_RUN) && enable_i;
  assign frozen   = (state_q == ST_DONE);
  assign cyc_ext  = 64'(cnt[CNT_CYCLES]);
  // Compare at 64 bits so a limit wider than the counter simply never fires.
  assign at_limit = active && (cyc_ext == LIMIT_M1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_RUN;
      ST_RUN: begin
        if (!enable_i)     state_d = ST_IDLE;
        else if (at_limit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) state_d = ST_IDLE;
  end

  // Cache tracking runs in every FSM state so enabling mid-miss stays consistent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= ST_IDLE;
      prev_cache_state_q <= CACHE_IDLE;
      miss_pending_q     <= 1'b0;
      count_q            <= '0;
    end else begin
      state_q            <= state_d;
      prev_cache_state_q <= cache_state_i;
      miss_pending_q     <= cache_stall_i;
      count_q            <= cnt[sel_i];
    end
  end

  assign miss_start = cache_stall_i && !miss_pending_q && (prev_cache_state_q == CACHE_IDLE) &&
                      ((cache_state_i == CACHE_WB) || (cache_state_i == CACHE_ALLOC));
  assign hit_ok     = !cache_stall_i && !miss_pending_q;

  always_comb begin
    ev = '0;
    if (active) begin
      ev[CNT_CYCLES]    = 1'b1;
      ev[CNT_STALLS]    = (hazard_stall_i || cache_stall_i) && !pc_mux_ctrl_i;
      ev[CNT_FLUSHES]   = flush_i;
      ev[CNT_RD_HITS]   = hit_ok && cache_read_i;
      ev[CNT_WR_HITS]   = hit_ok && !cache_read_i && cache_write_i;
      ev[CNT_RD_MISSES] = miss_start && cache_read_i;
      ev[CNT_WR_MISSES] = miss_start && !cache_read_i;
      ev[CNT_WB_MISSES] = miss_start && (cache_state_i == CACHE_WB);
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter #(
      .pWidth    (pCounterWidth),
      .pSaturate (pSaturate)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .inc_i      (ev[i]),
      .freeze_i   (frozen),
      .count_o    (cnt[i]),
      .overflow_o (ovf[i])
    );
  end

  assign count_o         = count_q;
  assign overflow_o      = ovf;
  assign limit_reached_o = frozen;

endmodule
